// File: rtl/segment_wr_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | segment_wr_ctrl: streams 4*size lines to four DMA segments, waits for acks |
// | Optional: SEGMENT_WR_CTRL_PERF_EN adds perf_cycles.   Revision: 1.0        |
// +----------------------------------------------------------------------------+
module segment_wr_ctrl #(
  parameter int ADDR_WIDTH = 64,
  parameter int SIZE_WIDTH = 17,
  parameter int DATA_WIDTH = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic [ADDR_WIDTH-1:0] wr_addr_s0,
  input  logic [ADDR_WIDTH-1:0] wr_addr_s1,
  input  logic [ADDR_WIDTH-1:0] wr_addr_s2,
  input  logic [ADDR_WIDTH-1:0] wr_addr_s3,
  input  logic [SIZE_WIDTH-1:0] size,
  output logic                  done,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  dma_wr_en,
  output logic [ADDR_WIDTH-1:0] dma_wr_addr,
  output logic [DATA_WIDTH-1:0] dma_wr_data,
  input  logic                  dma_wr_full,
  input  logic                  dma_wr_ack
`ifdef SEGMENT_WR_CTRL_PERF_EN
  ,
  output logic [31:0]           perf_cycles
`endif
);

  localparam int CNT_W = SIZE_WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE    = 2'd1,
    WAIT_ACK = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t                         state_q, state_d;
  logic [3:0][ADDR_WIDTH-1:0]     base_q, base_d;
  logic [SIZE_WIDTH-1:0]          size_q, size_d;
  logic [SIZE_WIDTH-1:0]          line_idx_q, line_idx_d;
  logic [1:0]                     seg_q, seg_d;
  logic [CNT_W-1:0]               ack_cnt_q, ack_cnt_d;
  logic                           done_q, done_d;
  logic                           w_writing;
`ifdef SEGMENT_WR_CTRL_PERF_EN
  logic [31:0]                    perf_q, perf_d;
  assign perf_cycles = perf_q;
`endif

  // A zero-size transfer must not accept or issue any line.
  assign w_writing   = (state_q == WRITE) && (size_q != '0);
  assign in_ready    = w_writing && !dma_wr_full;
  assign dma_wr_en   = w_writing && in_valid && !dma_wr_full;
  assign dma_wr_data = in_data;
  assign dma_wr_addr = base_q[seg_q] + ADDR_WIDTH'({line_idx_q, 6'b00_0000});
  assign done        = done_q;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    size_d     = size_q;
    line_idx_d = line_idx_q;
    seg_d      = seg_q;
    ack_cnt_d  = ack_cnt_q;
    done_d     = done_q;
`ifdef SEGMENT_WR_CTRL_PERF_EN
    perf_d     = perf_q;
    if ((state_q == WRITE || state_q == WAIT_ACK) && perf_q != 32'hFFFF_FFFF)
      perf_d = perf_q + 32'd1;
`endif

    if (state_q != IDLE && dma_wr_ack)
      ack_cnt_d = ack_cnt_q + CNT_W'(1);

    case (state_q)
      IDLE, DONE: begin
        if (go) begin
          base_d     = {wr_addr_s3, wr_addr_s2, wr_addr_s1, wr_addr_s0};
          size_d     = size;
          line_idx_d = '0;
          seg_d      = 2'd0;
          ack_cnt_d  = '0;
          done_d     = 1'b0;
          state_d    = WRITE;
`ifdef SEGMENT_WR_CTRL_PERF_EN
          perf_d     = '0;
`endif
        end
      end
      WRITE: begin
        if (size_q == '0) begin
          state_d = WAIT_ACK;
        end else if (dma_wr_en) begin
          if (line_idx_q == size_q - SIZE_WIDTH'(1)) begin
            line_idx_d = '0;
            seg_d      = seg_q + 2'd1;
            if (seg_q == 2'd3)
              state_d = WAIT_ACK;
          end else begin
            line_idx_d = line_idx_q + SIZE_WIDTH'(1);
          end
        end
      end
      WAIT_ACK: begin
        if (ack_cnt_q == {size_q, 2'b00}) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      size_q     <= '0;
      line_idx_q <= '0;
      seg_q      <= 2'd0;
      ack_cnt_q  <= '0;
      done_q     <= 1'b0;
`ifdef SEGMENT_WR_CTRL_PERF_EN
      perf_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      size_q     <= size_d;
      line_idx_q <= line_idx_d;
      seg_q      <= seg_d;
      ack_cnt_q  <= ack_cnt_d;
      done_q     <= done_d;
`ifdef SEGMENT_WR_CTRL_PERF_EN
      perf_q     <= perf_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_segment_wr_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_segment_wr_ctrl: scoreboard bench for segment_wr_ctrl. Revision: 1.0    |
// +----------------------------------------------------------------------------+
module tb_segment_wr_ctrl;
  localparam int AW = 64;
  localparam int SW = 17;
  localparam int DW = 512;

  logic          clk = 1'b0;
  logic          rst, go;
  logic [AW-1:0] a0, a1, a2, a3;
  logic [SW-1:0] size;
  logic          done, in_valid, in_ready, dma_wr_en, dma_wr_full;
  logic          dma_wr_ack, ack_drv, ack_same;
  logic [DW-1:0] in_data, dma_wr_data;
  logic [AW-1:0] dma_wr_addr;
`ifdef SEGMENT_WR_CTRL_PERF_EN
  logic [31:0]   perf_cycles;
`endif

  always #5 clk = ~clk;

  // Same-cycle ack mode answers every request in the cycle it is issued.
  assign dma_wr_ack = ack_same ? dma_wr_en : ack_drv;

  segment_wr_ctrl #(.ADDR_WIDTH(AW), .SIZE_WIDTH(SW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .go(go),
    .wr_addr_s0(a0), .wr_addr_s1(a1), .wr_addr_s2(a2), .wr_addr_s3(a3),
    .size(size), .done(done),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .dma_wr_en(dma_wr_en), .dma_wr_addr(dma_wr_addr), .dma_wr_data(dma_wr_data),
    .dma_wr_full(dma_wr_full), .dma_wr_ack(dma_wr_ack)
`ifdef SEGMENT_WR_CTRL_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [AW-1:0] addr_q[$];
  logic [DW-1:0] data_q[$];
  int            ack_due[$];
  int            cyc, sent, total, req_cnt, acks_seen, last_ack_cyc, ack_delay, go_cyc;
  bit            cur_pushed, full_toggle, done_s;

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int n);
    return {16{32'(n) ^ 32'hA5A5_0000}};
  endfunction

  // One clock: sample/score at negedge, then drive the next cycle's inputs.
  task automatic tick();
    logic acc;
    @(negedge clk);
    done_s = done;
    acc    = in_valid && in_ready;
    if (dma_wr_en) begin
      req_cnt++;
      chk("req_while_full", DW'(dma_wr_full), DW'(0));
      if (addr_q.size() == 0 || data_q.size() == 0) begin
        chk("unexpected_req", DW'(1), DW'(0));
      end else begin
        chk("wr_addr", DW'(dma_wr_addr), DW'(addr_q.pop_front()));
        chk("wr_data", dma_wr_data, data_q.pop_front());
      end
      if (!ack_same) ack_due.push_back(cyc + ack_delay);
    end
    if (dma_wr_ack) begin
      acks_seen++;
      last_ack_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (acc) begin
      sent++;
      cur_pushed = 1'b0;
    end
    if (sent < total && !cur_pushed) begin
      in_data = mk(sent);
      data_q.push_back(in_data);
      cur_pushed = 1'b1;
    end
    in_valid    = (sent < total);
    dma_wr_full = full_toggle ? ~dma_wr_full : 1'b0;
    ack_drv     = 1'b0;
    if (ack_due.size() > 0 && ack_due[0] <= cyc) begin
      void'(ack_due.pop_front());
      ack_drv = 1'b1;
    end
  endtask

  task automatic start(input int sz, input logic [AW-1:0] b0, input logic [AW-1:0] b1,
                       input logic [AW-1:0] b2, input logic [AW-1:0] b3);
    logic [AW-1:0] b[4];
    b = '{b0, b1, b2, b3};
    a0 = b0; a1 = b1; a2 = b2; a3 = b3;
    size = SW'(sz);
    go = 1'b1;
    total = 4 * sz; sent = 0; cur_pushed = 1'b0;
    req_cnt = 0; acks_seen = 0; last_ack_cyc = 0;
    addr_q.delete(); data_q.delete();
    for (int s = 0; s < 4; s++)
      for (int l = 0; l < sz; l++)
        addr_q.push_back(b[s] + AW'(64 * l));
    go_cyc = cyc;
    tick();
    go = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit, input int exp_acks);
    int k = 0;
    do begin
      tick();
      k++;
    end while (!done_s && k < limit);
    if (!done_s) begin
      chk({tag, "_timeout"}, DW'(0), DW'(1));
    end else begin
      chk({tag, "_acks"}, DW'(acks_seen), DW'(exp_acks));
      // done must rise after the final ack, no later than two cycles on.
      chk({tag, "_done_lat"},
          DW'((cyc - 1 - last_ack_cyc) >= 1 && (cyc - 1 - last_ack_cyc) <= 2), DW'(1));
    end
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; in_valid = 1'b0; in_data = '0; dma_wr_full = 1'b0;
    ack_drv = 1'b0; ack_same = 1'b0; full_toggle = 1'b0; ack_delay = 1;
    size = '0; a0 = '0; a1 = '0; a2 = '0; a3 = '0;
    cyc = 0; sent = 0; total = 0; req_cnt = 0; acks_seen = 0; last_ack_cyc = 0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_done", DW'(done), DW'(0));
    chk("rst_in_ready", DW'(in_ready), DW'(0));
    chk("rst_wr_en", DW'(dma_wr_en), DW'(0));

    // Basic: size 2, one ack per request in the same cycle.
    ack_same = 1'b1;
    start(2, 64'h1000, 64'h2000, 64'h3000, 64'h4000);
    wait_done("t1", 60, 8);
    chk("t1_reqs", DW'(req_cnt), DW'(8));
    repeat (3) tick();
    chk("t1_done_hold", DW'(done_s), DW'(1));
    chk("t1_in_ready_done", DW'(in_ready), DW'(0));
    chk("t1_wr_en_done", DW'(dma_wr_en), DW'(0));

    // Backpressure toggling, delayed acks, and a go that must be ignored.
    ack_same = 1'b0; ack_delay = 3; full_toggle = 1'b1;
    start(3, 64'hA000_0000, 64'hB000_0100, 64'hC000_0200, 64'hFFFF_FFFF_FFFF_FFC0);
    repeat (4) tick();
    go = 1'b1; a0 = 64'hDEAD_0000; size = SW'(7);
    tick();
    go = 1'b0;
    wait_done("t2", 300, 12);
    chk("t2_reqs", DW'(req_cnt), DW'(12));
    chk("t2_left", DW'(addr_q.size()), DW'(0));
    full_toggle = 1'b0; dma_wr_full = 1'b0;

    // size 1, no stalls, same-cycle acks.
    ack_same = 1'b1;
    start(1, 64'h10, 64'h20, 64'h30, 64'h40);
    wait_done("t3", 40, 4);
    chk("t3_reqs", DW'(req_cnt), DW'(4));
`ifdef SEGMENT_WR_CTRL_PERF_EN
    chk("t3_perf", DW'(perf_cycles), DW'(5));
    repeat (2) tick();
    chk("t3_perf_hold", DW'(perf_cycles), DW'(5));
`endif

    // Acks held back 20 cycles after each request.
    ack_same = 1'b0; ack_delay = 20;
    start(2, 64'h5000, 64'h6000, 64'h7000, 64'h8000);
    wait_done("t4", 200, 8);

    // size 0: done three cycles after go, no requests.
    start(0, 64'h1, 64'h2, 64'h3, 64'h4);
    tick();
    tick();
    chk("t5_done_early", DW'(done_s), DW'(0));
    tick();
    chk("t5_done", DW'(done_s), DW'(1));
    chk("t5_reqs", DW'(req_cnt), DW'(0));

    // Reset mid-transfer, stale acks in IDLE, then a fresh size-1 run.
    ack_delay = 6;
    begin
      int k = 0;
      start(2, 64'h9000, 64'hA000, 64'hB000, 64'hC000);
      while (sent < 3 && k < 50) begin
        tick();
        k++;
      end
      chk("t6_three_sent", DW'(sent), DW'(3));
    end
    in_valid = 1'b0; total = 0; sent = 0; rst = 1'b1;
    tick();
    rst = 1'b0;
    addr_q.delete(); data_q.delete(); cur_pushed = 1'b0;
    repeat (8) tick();
    chk("t6_idle_done", DW'(done_s), DW'(0));
    chk("t6_idle_ready", DW'(in_ready), DW'(0));
    ack_due.delete();
    ack_delay = 2;
    start(1, 64'hD000, 64'hE000, 64'hF000, 64'h1_0000);
    wait_done("t6", 60, 4);
    chk("t6_reqs", DW'(req_cnt), DW'(4));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
